// File: rtl/proc_io_hub.sv
// I/O responder for the processor bus: buffered input channels, handshaked
// output registers, masked fill interrupt and sticky underflow/overflow flags.
module proc_io_hub #(
  parameter int                NUBITS = 16,
  parameter int                NUIOIN = 2,
  parameter int                NUIOOU = 2,
  parameter logic [NUIOIN-1:0] ITRMSK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUBITS-1:0]          io_out,
  input  logic [$clog2(NUIOOU)-1:0]  addr_out,
  input  logic                       out_en,
  input  logic [$clog2(NUIOIN)-1:0]  addr_in,
  input  logic                       req_in,
  output logic [NUBITS-1:0]          io_in,
  output logic                       itr,
  input  logic [NUIOIN*NUBITS-1:0]   src_data,
  input  logic [NUIOIN-1:0]          src_valid,
  output logic [NUIOIN-1:0]          src_ready,
  output logic [NUIOOU*NUBITS-1:0]   snk_data,
  output logic [NUIOOU-1:0]          snk_valid,
  input  logic [NUIOOU-1:0]          snk_ready,
  output logic [NUIOIN-1:0]          err_udf,
  output logic [NUIOOU-1:0]          err_ovf,
  input  logic                       err_clr
);

  localparam int AIW = $clog2(NUIOIN);
  localparam int AOW = $clog2(NUIOOU);
  localparam logic [AIW:0] NIN = (AIW+1)'(NUIOIN);
  localparam logic [AOW:0] NOU = (AOW+1)'(NUIOOU);

  logic [NUIOIN-1:0][NUBITS-1:0] in_buf_p1;
  logic [NUIOIN-1:0]             in_full_p1;
  logic [NUIOOU-1:0][NUBITS-1:0] out_reg_p1;
  logic [NUIOOU-1:0]             out_vld_p1;
  logic                          itr_p1;
  logic [NUIOIN-1:0]             err_udf_p1;
  logic [NUIOOU-1:0]             err_ovf_p1;

  logic                          addr_in_ok;
  logic                          addr_out_ok;
  logic [NUIOIN-1:0]             fill;
  logic [NUIOIN-1:0]             consume;
  logic [NUIOIN-1:0]             udf_set;
  logic [NUIOOU-1:0]             wr;
  logic [NUIOOU-1:0]             accept;
  logic [NUIOOU-1:0]             ovf_set;

  always_comb begin
    addr_in_ok  = ({1'b0, addr_in} < NIN);
    addr_out_ok = ({1'b0, addr_out} < NOU);
    fill        = src_valid & ~in_full_p1;
    consume     = '0;
    udf_set     = '0;
    io_in       = '0;
    if (addr_in_ok && in_full_p1[addr_in])
      io_in = in_buf_p1[addr_in];
    if (req_in && addr_in_ok) begin
      if (in_full_p1[addr_in]) consume[addr_in] = 1'b1;
      else                     udf_set[addr_in] = 1'b1;
    end
    wr = '0;
    if (out_en && addr_out_ok)
      wr[addr_out] = 1'b1;
    accept  = out_vld_p1 & snk_ready;
    // A write only overflows if the pending word is not leaving this same edge.
    ovf_set = wr & out_vld_p1 & ~snk_ready;
  end

  // Stage p1: channel state, interrupt and sticky flags
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_buf_p1  <= '0;
      in_full_p1 <= '0;
      out_reg_p1 <= '0;
      out_vld_p1 <= '0;
      itr_p1     <= 1'b0;
      err_udf_p1 <= '0;
      err_ovf_p1 <= '0;
    end else begin
      for (int i = 0; i < NUIOIN; i++)
        if (fill[i]) in_buf_p1[i] <= src_data[i*NUBITS +: NUBITS];
      in_full_p1 <= (in_full_p1 | fill) & ~consume;
      for (int j = 0; j < NUIOOU; j++)
        if (wr[j]) out_reg_p1[j] <= io_out;
      out_vld_p1 <= (out_vld_p1 & ~accept) | wr;
      itr_p1     <= |(fill & ITRMSK);
      // New error events take priority over a coincident clear.
      err_udf_p1 <= (err_clr ? '0 : err_udf_p1) | udf_set;
      err_ovf_p1 <= (err_clr ? '0 : err_ovf_p1) | ovf_set;
    end
  end

  assign src_ready = ~in_full_p1;
  assign snk_data  = out_reg_p1;
  assign snk_valid = out_vld_p1;
  assign itr       = itr_p1;
  assign err_udf   = err_udf_p1;
  assign err_ovf   = err_ovf_p1;

endmodule

// File: tb/tb_proc_io_hub.sv
// Bench for proc_io_hub: directed scenarios plus a randomized run against a
// transaction-level channel model, across three interrupt masks.
module tb_proc_io_hub;

  localparam int NB = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] io_out;
  logic        addr_out;
  logic        out_en;
  logic        addr_in;
  logic        req_in;
  logic [31:0] src_data;
  logic [1:0]  src_valid;
  logic [1:0]  snk_ready;
  logic        err_clr;

  logic [15:0] io_in,     io_in_b,     io_in_c;
  logic        itr,       itr_b,       itr_c;
  logic [1:0]  src_ready, src_ready_b, src_ready_c;
  logic [31:0] snk_data,  snk_data_b,  snk_data_c;
  logic [1:0]  snk_valid, snk_valid_b, snk_valid_c;
  logic [1:0]  err_udf,   err_udf_b,   err_udf_c;
  logic [1:0]  err_ovf,   err_ovf_b,   err_ovf_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_io_hub #(.NUBITS(NB), .NUIOIN(2), .NUIOOU(2), .ITRMSK(2'b10)) u_dut (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .addr_in(addr_in), .req_in(req_in), .io_in(io_in), .itr(itr),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .err_udf(err_udf), .err_ovf(err_ovf), .err_clr(err_clr));

  proc_io_hub #(.NUBITS(NB), .NUIOIN(2), .NUIOOU(2), .ITRMSK(2'b11)) u_m11 (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .addr_in(addr_in), .req_in(req_in), .io_in(io_in_b), .itr(itr_b),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_b),
    .snk_data(snk_data_b), .snk_valid(snk_valid_b), .snk_ready(snk_ready),
    .err_udf(err_udf_b), .err_ovf(err_ovf_b), .err_clr(err_clr));

  proc_io_hub #(.NUBITS(NB), .NUIOIN(2), .NUIOOU(2), .ITRMSK(2'b00)) u_m00 (
    .clk(clk), .rst(rst), .io_out(io_out), .addr_out(addr_out), .out_en(out_en),
    .addr_in(addr_in), .req_in(req_in), .io_in(io_in_c), .itr(itr_c),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready_c),
    .snk_data(snk_data_c), .snk_valid(snk_valid_c), .snk_ready(snk_ready),
    .err_udf(err_udf_c), .err_ovf(err_ovf_c), .err_clr(err_clr));

  // Reference model: contents of each channel as seen from outside
  logic [15:0] m_in_word [2];
  bit          m_in_has  [2];
  logic [15:0] m_out_word[2];
  bit          m_out_pend[2];
  logic [1:0]  m_udf, m_ovf;
  bit          m_itr[3];
  logic [1:0]  masks[3] = '{2'b10, 2'b11, 2'b00};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src_valid = 2'b00; out_en = 1'b0; req_in = 1'b0; err_clr = 1'b0;
    snk_ready = 2'b00; addr_in = 1'b0; addr_out = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    src_valid = 2'b11; src_data = 32'hA5A5_5A5A;
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h1111;
    req_in = 1'b0; addr_in = 1'b0; snk_ready = 2'b00; err_clr = 1'b0;
    tick(); tick();
    idle(); rst = 1'b1; #1;
    checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL reset_src_ready got %b want 11", src_ready); end
    checks++; if (snk_valid !== 2'b00) begin errors++; $display("FAIL reset_snk_valid got %b want 00", snk_valid); end
    checks++; if (itr !== 1'b0 || itr_b !== 1'b0) begin errors++; $display("FAIL reset_itr got %b%b want 00", itr, itr_b); end
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL reset_io_in got %h want 0000", io_in); end
    checks++; if (err_udf !== 2'b00 || err_ovf !== 2'b00) begin errors++; $display("FAIL reset_flags got udf %b ovf %b want 00", err_udf, err_ovf); end
    checks++; if (snk_data !== 32'h0) begin errors++; $display("FAIL reset_snk_data got %h want 0", snk_data); end
  endtask

  task automatic test_read_path();
    src_data = {16'h1234, 16'h0000}; src_valid = 2'b10;
    tick();
    src_valid = 2'b00; addr_in = 1'b1; #1;
    checks++; if (itr !== 1'b1) begin errors++; $display("FAIL rd_itr_high got %b want 1", itr); end
    checks++; if (itr_c !== 1'b0) begin errors++; $display("FAIL rd_itr_masked got %b want 0", itr_c); end
    checks++; if (src_ready !== 2'b01) begin errors++; $display("FAIL rd_src_ready_full got %b want 01", src_ready); end
    checks++; if (io_in !== 16'h1234) begin errors++; $display("FAIL rd_io_in got %h want 1234", io_in); end
    tick();
    checks++; if (itr !== 1'b0) begin errors++; $display("FAIL rd_itr_one_cycle got %b want 0", itr); end
    req_in = 1'b1;
    tick();
    req_in = 1'b0; #1;
    checks++; if (src_ready !== 2'b11) begin errors++; $display("FAIL rd_src_ready_back got %b want 11", src_ready); end
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL rd_io_in_empty got %h want 0000", io_in); end
    checks++; if (err_udf !== 2'b00) begin errors++; $display("FAIL rd_no_udf got %b want 00", err_udf); end
    req_in = 1'b1;
    tick();
    req_in = 1'b0; #1;
    checks++; if (err_udf !== 2'b10) begin errors++; $display("FAIL rd_udf got %b want 10", err_udf); end
    err_clr = 1'b1; tick(); err_clr = 1'b0;
  endtask

  task automatic test_write_path();
    snk_ready = 2'b00; out_en = 1'b1; addr_out = 1'b0; io_out = 16'hBEEF;
    tick();
    checks++; if (snk_valid !== 2'b01) begin errors++; $display("FAIL wr_valid got %b want 01", snk_valid); end
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL wr_first_no_ovf got %b want 00", err_ovf); end
    io_out = 16'hCAFE;
    tick();
    out_en = 1'b0; #1;
    checks++; if (snk_data[15:0] !== 16'hCAFE) begin errors++; $display("FAIL wr_overwrite_data got %h want cafe", snk_data[15:0]); end
    checks++; if (err_ovf !== 2'b01) begin errors++; $display("FAIL wr_ovf got %b want 01", err_ovf); end
    err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL wr_ovf_clear got %b want 00", err_ovf); end
    snk_ready = 2'b01; tick(); snk_ready = 2'b00; #1;
    checks++; if (snk_valid !== 2'b00) begin errors++; $display("FAIL wr_accept got %b want 00", snk_valid); end
  endtask

  task automatic test_write_accept();
    out_en = 1'b1; addr_out = 1'b1; io_out = 16'h1111;
    tick();
    snk_ready = 2'b10; io_out = 16'h0007;
    tick();
    out_en = 1'b0; snk_ready = 2'b00; #1;
    checks++; if (snk_valid[1] !== 1'b1) begin errors++; $display("FAIL wa_valid got %b want 1", snk_valid[1]); end
    checks++; if (snk_data[31:16] !== 16'h0007) begin errors++; $display("FAIL wa_data got %h want 0007", snk_data[31:16]); end
    checks++; if (err_ovf !== 2'b00) begin errors++; $display("FAIL wa_no_ovf got %b want 00", err_ovf); end
    snk_ready = 2'b10; tick(); snk_ready = 2'b00; #1;
    checks++; if (snk_valid !== 2'b00) begin errors++; $display("FAIL wa_drain got %b want 00", snk_valid); end
  endtask

  task automatic test_itr_merge();
    src_data = {16'h00B1, 16'h00A0}; src_valid = 2'b11;
    tick();
    src_valid = 2'b00; #1;
    checks++; if (itr_b !== 1'b1) begin errors++; $display("FAIL itr_merge_m11 got %b want 1", itr_b); end
    checks++; if (itr_c !== 1'b0) begin errors++; $display("FAIL itr_merge_m00 got %b want 0", itr_c); end
    tick();
    checks++; if (itr_b !== 1'b0) begin errors++; $display("FAIL itr_single_pulse got %b want 0", itr_b); end
    req_in = 1'b1; addr_in = 1'b0; tick();
    addr_in = 1'b1; tick();
    req_in = 1'b0;
    src_valid = 2'b01; tick();
    checks++; if (itr_b !== 1'b1) begin errors++; $display("FAIL itr_consec_a got %b want 1", itr_b); end
    src_valid = 2'b10; tick();
    checks++; if (itr_b !== 1'b1) begin errors++; $display("FAIL itr_consec_b got %b want 1", itr_b); end
    src_valid = 2'b00; tick();
    checks++; if (itr_b !== 1'b0) begin errors++; $display("FAIL itr_consec_end got %b want 0", itr_b); end
  endtask

  task automatic test_reset_mid();
    out_en = 1'b1; addr_out = 1'b0; io_out = 16'h5555; snk_ready = 2'b00;
    tick();
    out_en = 1'b0; #1;
    checks++; if (src_ready !== 2'b00 || snk_valid !== 2'b01) begin errors++; $display("FAIL mid_setup got rdy %b vld %b want 00 01", src_ready, snk_valid); end
    rst = 1'b0; tick(); rst = 1'b1; addr_in = 1'b0; #1;
    checks++; if (src_ready !== 2'b11 || snk_valid !== 2'b00) begin errors++; $display("FAIL mid_cleared got rdy %b vld %b want 11 00", src_ready, snk_valid); end
    checks++; if (io_in !== 16'h0) begin errors++; $display("FAIL mid_io_in got %h want 0000", io_in); end
    req_in = 1'b1; tick(); req_in = 1'b0; #1;
    checks++; if (err_udf !== 2'b01) begin errors++; $display("FAIL mid_udf got %b want 01", err_udf); end
  endtask

  task automatic test_random();
    logic [1:0]  fills;
    logic [15:0] exp_io;
    logic [31:0] exp_snk;
    logic [1:0]  exp_rdy, exp_vld;
    idle();
    rst = 1'b0; tick(); rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_in_word[i] = '0; m_in_has[i] = 0; m_out_word[i] = '0; m_out_pend[i] = 0;
    end
    m_udf = '0; m_ovf = '0;
    for (int k = 0; k < 3; k++) m_itr[k] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      src_valid = 2'($urandom); src_data = $urandom;
      req_in = ($urandom_range(0, 2) == 0); addr_in = 1'($urandom);
      out_en = ($urandom_range(0, 2) == 0); addr_out = 1'($urandom); io_out = 16'($urandom);
      snk_ready = 2'($urandom); err_clr = ($urandom_range(0, 9) == 0);
      #1;
      exp_io  = m_in_has[addr_in] ? m_in_word[addr_in] : 16'h0;
      exp_rdy = {~m_in_has[1], ~m_in_has[0]};
      exp_vld = {m_out_pend[1], m_out_pend[0]};
      exp_snk = {m_out_word[1], m_out_word[0]};
      checks++; if (io_in !== exp_io) begin errors++; $display("FAIL rnd_io_in cyc %0d got %h want %h", cyc, io_in, exp_io); end
      checks++; if (src_ready !== exp_rdy) begin errors++; $display("FAIL rnd_src_ready cyc %0d got %b want %b", cyc, src_ready, exp_rdy); end
      checks++; if (snk_valid !== exp_vld || snk_data !== exp_snk) begin errors++; $display("FAIL rnd_sink cyc %0d got %b %h want %b %h", cyc, snk_valid, snk_data, exp_vld, exp_snk); end
      checks++; if (itr !== m_itr[0] || itr_b !== m_itr[1] || itr_c !== m_itr[2]) begin errors++; $display("FAIL rnd_itr cyc %0d got %b%b%b want %b%b%b", cyc, itr, itr_b, itr_c, m_itr[0], m_itr[1], m_itr[2]); end
      checks++; if (err_udf !== m_udf || err_ovf !== m_ovf) begin errors++; $display("FAIL rnd_flags cyc %0d got %b %b want %b %b", cyc, err_udf, err_ovf, m_udf, m_ovf); end
      // Advance the model by one clock edge
      if (err_clr) begin m_udf = '0; m_ovf = '0; end
      fills = '0;
      for (int i = 0; i < 2; i++) fills[i] = src_valid[i] && !m_in_has[i];
      if (req_in) begin
        if (m_in_has[addr_in]) m_in_has[addr_in] = 0;
        else m_udf[addr_in] = 1'b1;
      end
      for (int i = 0; i < 2; i++)
        if (fills[i]) begin m_in_has[i] = 1; m_in_word[i] = src_data[i*16 +: 16]; end
      for (int j = 0; j < 2; j++) begin
        if (out_en && addr_out == j) begin
          if (m_out_pend[j] && !snk_ready[j]) m_ovf[j] = 1'b1;
          m_out_word[j] = io_out; m_out_pend[j] = 1;
        end else if (m_out_pend[j] && snk_ready[j]) begin
          m_out_pend[j] = 0;
        end
      end
      for (int k = 0; k < 3; k++) m_itr[k] = (fills & masks[k]) != 2'b00;
      tick();
    end
    idle();
  endtask

  initial begin
    io_out = '0; src_data = '0;
    idle();
    rst = 1'b0;
    test_reset();
    test_read_path();
    test_write_path();
    test_write_accept();
    test_itr_merge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_io_hub.md
# proc_io_hub

Responder end of the `processor` I/O bus. It buffers words from `NUIOIN` external sources and returns them to the core on `req_in`/`addr_in`. It captures core writes on `out_en`/`addr_out` into `NUIOOU` output registers with valid/ready handshakes, and raises the core's `itr` line when masked input channels receive data. It sits beside `processor` at the top level, wired port-to-port to its I/O pins.

## Interface

Parameters:
- `NUBITS`, 16, data word width; must match the processor.
- `NUIOIN`, 2, number of input channels; at least 2.
- `NUIOOU`, 2, number of output channels; at least 2.
- `ITRMSK`, 0, `NUIOIN`-bit mask; bit i set means channel i filling raises `itr`.

Ports:
- `clk`, in, 1, single clock; all logic on rising edge.
- `rst`, in, 1, reset, synchronous and active-low.
- `io_out`, in, `NUBITS`, write data from the core.
- `addr_out`, in, `$clog2(NUIOOU)`, write channel select.
- `out_en`, in, 1, core write strobe.
- `addr_in`, in, `$clog2(NUIOIN)`, read channel select.
- `req_in`, in, 1, core read strobe.
- `io_in`, out, `NUBITS`, read data to the core.
- `itr`, out, 1, interrupt pulse to the core.
- `src_data`, in, `NUIOIN*NUBITS`, source words; channel i occupies bits [i*NUBITS +: NUBITS].
- `src_valid`, in, `NUIOIN`, source valid per channel.
- `src_ready`, out, `NUIOIN`, hub ready per channel.
- `snk_data`, out, `NUIOOU*NUBITS`, output words, same packing as `src_data`.
- `snk_valid`, out, `NUIOOU`, output valid per channel.
- `snk_ready`, in, `NUIOOU`, sink ready per channel.
- `err_udf`, out, `NUIOIN`, sticky flag: core read an empty channel.
- `err_ovf`, out, `NUIOOU`, sticky flag: core overwrote an unaccepted word.
- `err_clr`, in, 1, clears both sticky flag vectors.

## Operation

Input channels each hold a one-word buffer with a `full` bit.
- `src_ready[i] = ~full[i]`; this is a register-driven signal with no combinational path from `src_valid`.
- A source transfer occurs when `src_valid[i] & src_ready[i]` at a clock edge. The buffer loads and `full[i]` sets.
- Read path: `io_in` is a combinational mux of buffer[`addr_in`].
  - If the addressed channel is empty, `io_in` is 0.
  - If `addr_in >= NUIOIN`, `io_in` is 0 and the read has no other effect.
- Read consumption: at an edge where `req_in` is high and `full[addr_in]` is set, `full[addr_in]` clears.
- Reading an empty valid channel sets `err_udf[addr_in]`.
- Simultaneous source transfer and core read on the same channel cannot occur, because ready is low while full.

Output channels each hold a register and a `valid` bit.
- On an `out_en` edge, `io_out` loads into register[`addr_out`] and `snk_valid[addr_out]` sets.
- If `addr_out >= NUIOOU`, the write is ignored.
- A sink accept occurs when `snk_valid[j] & snk_ready[j]`; `snk_valid[j]` clears at that edge.
- Write and accept in the same cycle on the same channel: the new word loads, `snk_valid` stays 1, and there is no overflow.
- Write while `snk_valid` is 1 and `snk_ready` is 0: the new word overwrites the old one, `snk_valid` stays 1, and `err_ovf[j]` sets.

Interrupt:
- `itr` pulses for 1 cycle after any edge where a channel with `ITRMSK` bit set goes from empty to full.
- Multiple channels filling in the same cycle produce a single pulse.
- Fills on consecutive cycles produce consecutive pulses.

Errors:
- `err_clr` clears both flag vectors.
- If `err_clr` coincides with a new error event, the set wins.

## Timing

- Reset: with `rst` low at an edge, all of the following return to 0:
  - every `full` and `valid` bit and every data register;
  - `itr`, `err_udf`, `err_ovf`.
  - Consequently `src_ready` = all ones and `io_in` = 0.
- Reset mid-transfer discards all buffered and pending words. Handshakes asserted in the reset cycle are not taken.
- Source to core latency: a word accepted at edge N is readable on `io_in` in cycle N+1.
- Per-channel throughput: one word per 2 cycles per input channel.
- `itr` is registered: for a fill at edge N, `itr` is high during cycle N+1.
- Core write to sink: a write at edge N gives `snk_valid` high in cycle N+1.
- A core read at edge N of a full channel gives `src_ready` high in cycle N+1.

## Test plan

- Reset behaviour: hold `rst` low 2 cycles with `src_valid`=11 and `out_en`=1. Then: `src_ready`=11, `snk_valid`=00, `itr`=0, `io_in`=0, no flags set.
- Read path: push 0x1234 on ch1 with `ITRMSK`=2'b10. Then:
  - `itr` high exactly 1 cycle;
  - `addr_in`=1 gives `io_in`=0x1234;
  - `req_in` clears ch1 and `src_ready[1]` returns to 1 the next cycle;
  - a second read gives `io_in`=0 and `err_udf`=2'b10.
- Write path: `out_en` with 0xBEEF to ch0, `snk_ready`=0, then 0xCAFE to ch0. Then `snk_data` ch0=0xCAFE and `err_ovf`=2'b01. Pulsing `err_clr` clears the flag.
- Simultaneous write and accept: `snk_valid[1]`=1, `snk_ready[1]`=1, `out_en` to ch1 with 0x0007. Then `snk_valid[1]` stays 1, data=0x0007, `err_ovf` stays 0.
- Interrupt merging and masking: ch0 and ch1 fill in the same cycle with `ITRMSK`=11 gives one `itr` pulse. Repeat with `ITRMSK`=00 gives no pulse.
- Reset mid-operation: with both inputs full and one output pending, assert `rst` for 1 cycle. Then all `full`/`valid` bits are 0 and the next read returns 0 and sets `err_udf`.
